varcic_interp: RTL and testbench

//  Variable-rate CIC interpolator for the TX path; the counterpart of the RX varcic decimators.

---
 rtl/varcic_pkg.sv | 38 +++
 rtl/varcic_round.sv | 45 ++++
 rtl/varcic_interp.sv | 135 +++++++++++++
 tb/tb_varcic_interp.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/varcic_pkg.sv
// varcic_pkg: rate codes, bit-growth table and output-MSB lookup shared by the varcic interpolator and decimators.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package varcic_pkg;

  localparam logic [7:0] RATE_4  = 8'd4;
  localparam logic [7:0] RATE_5  = 8'd5;
  localparam logic [7:0] RATE_8  = 8'd8;
  localparam logic [7:0] RATE_10 = 8'd10;
  localparam logic [7:0] RATE_20 = 8'd20;
  localparam logic [7:0] RATE_40 = 8'd40;

  // Any code outside the supported set runs the filter at the slowest rate.
  function automatic logic [7:0] rate_sanitize(input logic [7:0] r);
    case (r)
      RATE_4, RATE_5, RATE_8, RATE_10, RATE_20: return r;
      default:                                  return RATE_40;
    endcase
  endfunction

  // clog2(R^(N-1)) for N=3: the gain normalisation shift for each rate.
  function automatic int rate_growth(input logic [7:0] r);
    case (r)
      RATE_4:  return 4;
      RATE_5:  return 5;
      RATE_8:  return 6;
      RATE_10: return 7;
      RATE_20: return 9;
      default: return 11;
    endcase
  endfunction

  // Index of the accumulator bit that becomes the output sign bit.
  function automatic int out_msb(input logic [7:0] r, input int in_width);
    return in_width + rate_growth(r) - 1;
  endfunction

endpackage

// File: rtl/varcic_round.sv
// varcic_round: selects the OUT_WIDTH output window from the last integrator and rounds half up.
// Latency: combinational. Backpressure: none.
// Ports: i_acc integrator value, i_rate active (sanitised) rate, o_data rounded sample.
// Macro OUT_SAT_EN: clamp the rounded result instead of letting 0x7FFF+1 wrap to 0x8000.
module varcic_round
  import varcic_pkg::*;
#(
  parameter int ACC_WIDTH = 34,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16
) (
  input  logic signed [ACC_WIDTH-1:0] i_acc,
  input  logic        [7:0]           i_rate,
  output logic signed [OUT_WIDTH-1:0] o_data
);

  int                   w_shift;
  logic [OUT_WIDTH:0]   w_win;   // [OUT_WIDTH:1] = selected window, [0] = round bit
  logic [OUT_WIDTH-1:0] w_sel;
  logic                 w_rnd;

  always_comb begin
    w_shift = out_msb(i_rate, IN_WIDTH) - OUT_WIDTH;
    w_win   = (OUT_WIDTH+1)'(i_acc >>> w_shift);
    w_sel   = w_win[OUT_WIDTH:1];
    w_rnd   = w_win[0];
  end

`ifdef OUT_SAT_EN
  logic [OUT_WIDTH:0] w_sum;

  always_comb begin
    w_sum = {w_sel[OUT_WIDTH-1], w_sel} + {{OUT_WIDTH{1'b0}}, w_rnd};
    // Differing top two bits means the sum left the OUT_WIDTH range.
    if (w_sum[OUT_WIDTH] != w_sum[OUT_WIDTH-1])
      o_data = w_sum[OUT_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else
      o_data = w_sum[OUT_WIDTH-1:0];
  end
`else
  always_comb o_data = w_sel + {{(OUT_WIDTH-1){1'b0}}, w_rnd};
`endif

endmodule

// File: rtl/varcic_interp.sv
// varcic_interp: variable-rate CIC interpolator (STAGES combs at low rate, STAGES integrators at high rate).
// Latency: i_out_tick sampled at edge k -> o_out_strobe/o_out_data valid after edge k+1; one tick per clock max.
// Backpressure: one-deep holding register; strobe while !o_in_ready drops the sample and pulses o_overrun.
// Ports: i_clock, i_reset (sync, active-high), i_interpolation (R: 4,5,8,10,20,40; others act as 40),
//  i_out_tick, i_in_strobe, i_in_data, o_in_ready, o_out_strobe, o_out_data, o_underrun, o_overrun.
// Macro OUT_SAT_EN (used inside varcic_round) selects saturating instead of wrapping output rounding.
module varcic_interp
  import varcic_pkg::*;
#(
  parameter int STAGES    = 3,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int L2MD      = 6,
  parameter int ACC_WIDTH = IN_WIDTH + STAGES * L2MD
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic        [7:0]           i_interpolation,
  input  logic                        i_out_tick,
  input  logic                        i_in_strobe,
  input  logic signed [IN_WIDTH-1:0]  i_in_data,
  output logic                        o_in_ready,
  output logic                        o_out_strobe,
  output logic signed [OUT_WIDTH-1:0] o_out_data,
  output logic                        o_underrun,
  output logic                        o_overrun
);

  logic signed [IN_WIDTH-1:0]  r_hold;
  logic                        r_in_ready;
  logic                        r_underrun;
  logic                        r_overrun;
  logic        [L2MD-1:0]      r_phase;
  logic        [7:0]           r_rate_q;
  logic signed [ACC_WIDTH-1:0] r_comb [STAGES];
  logic signed [ACC_WIDTH-1:0] r_last [STAGES];  // previous input of each comb stage
  logic signed [ACC_WIDTH-1:0] r_int  [STAGES];
  logic                        r_tick_d;
  logic                        r_out_strobe;
  logic signed [OUT_WIDTH-1:0] r_out_data;

  logic                        w_frame;      // tick at phase 0: low-rate sample boundary
  logic                        w_accept;
  logic                        w_phase_last;
  logic signed [ACC_WIDTH-1:0] w_x;
  logic signed [ACC_WIDTH-1:0] w_stuff;
  logic signed [OUT_WIDTH-1:0] w_round;

  always_comb begin
    w_frame      = i_out_tick && (r_phase == '0);
    w_accept     = i_in_strobe && r_in_ready;
    w_phase_last = (r_phase == L2MD'(r_rate_q - 8'd1));
    // An empty holding register feeds zero into the comb chain.
    w_x          = r_in_ready ? '0 : ACC_WIDTH'(r_hold);
    w_stuff      = (r_phase == '0) ? r_comb[STAGES-1] : '0;
  end

  // Input handshake; runs whether or not a tick is present.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_hold     <= '0;
      r_in_ready <= 1'b1;
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_underrun <= w_frame && r_in_ready;
      r_overrun  <= i_in_strobe && !r_in_ready;
      if (w_accept) begin
        r_hold     <= i_in_data;
        r_in_ready <= 1'b0;
      end else if (w_frame) begin
        r_in_ready <= 1'b1;
      end
    end
  end

  // Phase counter, rate capture, comb and integrator chains.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_phase  <= '0;
      r_rate_q <= RATE_40;
      for (int k = 0; k < STAGES; k++) begin
        r_comb[k] <= '0;
        r_last[k] <= '0;
        r_int[k]  <= '0;
      end
    end else if (i_out_tick) begin
      r_phase <= w_phase_last ? '0 : r_phase + 1'b1;
      if (w_frame) begin
        // Rate only changes on a frame boundary so a frame never splits.
        r_rate_q  <= rate_sanitize(i_interpolation);
        r_comb[0] <= w_x - r_last[0];
        r_last[0] <= w_x;
        for (int k = 1; k < STAGES; k++) begin
          r_comb[k] <= r_comb[k-1] - r_last[k];
          r_last[k] <= r_comb[k-1];
        end
      end
      r_int[0] <= r_int[0] + w_stuff;
      for (int k = 1; k < STAGES; k++)
        r_int[k] <= r_int[k] + r_int[k-1];
    end
  end

  varcic_round #(
    .ACC_WIDTH (ACC_WIDTH),
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_round (
    .i_acc  (r_int[STAGES-1]),
    .i_rate (r_rate_q),
    .o_data (w_round)
  );

  // Output stage: one clock after the integrators settle on a tick.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tick_d     <= 1'b0;
      r_out_strobe <= 1'b0;
      r_out_data   <= '0;
    end else begin
      r_tick_d     <= i_out_tick;
      r_out_strobe <= r_tick_d;
      if (r_tick_d)
        r_out_data <= w_round;
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_out_strobe = r_out_strobe;
  assign o_out_data   = r_out_data;
  assign o_underrun   = r_underrun;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_varcic_interp.sv
// tb_varcic_interp: directed scoreboard bench for varcic_interp.
// Tick driver pushes one expected entry per tick; a negedge monitor pops on every output strobe.
// A feeder process keeps the holding register topped up when enabled, or sends queued manual samples.
module tb_varcic_interp;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic        [7:0]  rate = 8'd8;
  logic               tick = 1'b0;
  logic               strobe = 1'b0;
  logic signed [15:0] din = '0;
  logic               in_ready;
  logic               out_strobe;
  logic signed [15:0] dout;
  logic               underrun;
  logic               overrun;

  always #5 clk = ~clk;

  varcic_interp dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_interpolation (rate),
    .i_out_tick      (tick),
    .i_in_strobe     (strobe),
    .i_in_data       (din),
    .o_in_ready      (in_ready),
    .o_out_strobe    (out_strobe),
    .o_out_data      (dout),
    .o_underrun      (underrun),
    .o_overrun       (overrun)
  );

  int errors = 0;
  int checks = 0;

  bit                 chk_q[$];
  logic signed [15:0] exp_q[$];
  int                 tick_n = 0;
  int                 ur_ticks[$];
  int                 ovr_cnt = 0;
  bit                 feed_en = 1'b0;
  logic signed [15:0] feed_val = '0;
  logic signed [15:0] man_q[$];

  // R=4 impulse of 16: (1+z^-1+z^-2+z^-3)^3 coefficients, divided by 16 and rounded.
  int imp_tbl [10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && overrun) ovr_cnt++;
    if (!rst && out_strobe) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_strobe_unexpected: got strobe with data %0d, required no strobe (t=%0t)", dout, $time);
      end else begin
        bit                 c;
        logic signed [15:0] e;
        c = chk_q.pop_front();
        e = exp_q.pop_front();
        if (c) check("out_data", int'(dout), int'(e));
      end
    end
  end

  // Input feeder.
  always @(posedge clk) begin
    #1;
    if (man_q.size() > 0) begin
      strobe = 1'b1;
      din    = man_q.pop_front();
    end else if (feed_en && in_ready) begin
      strobe = 1'b1;
      din    = feed_val;
    end else begin
      strobe = 1'b0;
    end
  end

  // Issue n ticks (gap idle cycles between them). Ticks with index >= chk_from expect exp_val;
  // imp selects the impulse table instead. Call with time at posedge+1.
  task automatic run_ticks(input int n, input int gap, input int chk_from, input int exp_val, input bit imp);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      if (imp) begin
        chk_q.push_back(1'b1);
        if (tick_n >= 14 && tick_n < 24) exp_q.push_back(16'(imp_tbl[tick_n-14]));
        else                             exp_q.push_back(16'sd0);
      end else begin
        chk_q.push_back(tick_n >= chk_from);
        exp_q.push_back(16'(exp_val));
      end
      @(posedge clk); #1;
      if (underrun) ur_ticks.push_back(tick_n);
      tick_n++;
      if (gap > 0) begin
        tick = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    tick = 1'b0;
  endtask

  // Drain outstanding outputs, then reset with a tick present in the reset cycle (must be ignored).
  task automatic drain_and_reset();
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    feed_en = 1'b0;
    rst     = 1'b1;
    tick    = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    tick_n = 0;
    ur_ticks.delete();
    ovr_cnt = 0;
    check("post_reset_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_strobe", int'(out_strobe), 0);
    check("reset_out_data",   int'(dout), 0);
    check("reset_in_ready",   int'(in_ready), 1);
    check("reset_underrun",   int'(underrun), 0);
    check("reset_overrun",    int'(overrun), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Overrun then impulse at R=4: 16 is kept, 99 is dropped.
    rate = 8'd4;
    man_q.push_back(16'sd16);
    man_q.push_back(16'sd99);
    repeat (4) @(posedge clk);
    #1;
    check("overrun_count", ovr_cnt, 1);
    check("in_ready_after_overrun", int'(in_ready), 0);
    run_ticks(30, 1, 0, 0, 1'b1);

    // DC at R=8 settles to 1000, then a mid-frame switch to R=40 with feed stopped.
    drain_and_reset();
    rate = 8'd8;
    feed_val = 16'sd1000;
    feed_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run_ticks(64, 1, 50, 1000, 1'b0);
    check("r8_underrun_count", ur_ticks.size(), 0);
    run_ticks(3, 0, 100000, 0, 1'b0);
    rate = 8'd40;
    feed_en = 1'b0;
    run_ticks(93, 0, 100000, 0, 1'b0);
    check("ratechg_underrun_count", ur_ticks.size(), 2);
    check("ratechg_first_underrun", (ur_ticks.size() > 0) ? ur_ticks[0] : -1, 112);
    check("ratechg_second_underrun", (ur_ticks.size() > 1) ? ur_ticks[1] : -1, 152);

    // R=10: feed stops, underrun every 10 ticks from tick 70, output decays to 0.
    drain_and_reset();
    rate = 8'd10;
    feed_val = 16'sd1000;
    feed_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run_ticks(60, 0, 100000, 0, 1'b0);
    feed_en = 1'b0;
    run_ticks(100, 0, 140, 0, 1'b0);
    check("r10_underrun_count", ur_ticks.size(), 9);
    check("r10_first_underrun", (ur_ticks.size() > 0) ? ur_ticks[0] : -1, 70);

    // DC at R=5: 1000*25/32 = 781.25 -> 781.
    drain_and_reset();
    rate = 8'd5;
    feed_val = 16'sd1000;
    feed_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run_ticks(60, 2, 40, 781, 1'b0);
    check("r5_underrun_count", ur_ticks.size(), 0);

    // Full-scale step at R=4 (unity gain): -32768 then +32767.
    drain_and_reset();
    rate = 8'd4;
    feed_val = -16'sd32768;
    feed_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run_ticks(40, 0, 30, -32768, 1'b0);
    feed_val = 16'sd32767;
    run_ticks(50, 0, 80, 32767, 1'b0);
    check("fs_underrun_count", ur_ticks.size(), 0);

    repeat (4) @(posedge clk);
    #1;
    check("final_scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
